// File: rtl/spi_ram_master_seq.sv
// Host-side SPI master that turns one byte read/write request into the two-frame SPI RAM command sequence.
// Optional SPI_ADDR_CACHE_EN: skip the address frame when the address matches the last one of the same type.
module spi_ram_master_seq #(
    parameter int GAP_CYCLES = 2,
    parameter int RD_LAT     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {IDLE, SHIFT, TAIL, WAIT, CAPT, GAP, DONE} state_t;

    localparam int CNT_MAX = (GAP_CYCLES > RD_LAT) ? ((GAP_CYCLES > 8) ? GAP_CYCLES : 8)
                                                   : ((RD_LAT > 8) ? RD_LAT : 8);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(7);

    state_t           state_reg, state_next;
    logic [3:0]       bitcnt_reg, bitcnt_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             frame_reg, frame_next;
    logic             write_reg, write_next;
    logic [7:0]       addr_reg, addr_next;
    logic [7:0]       wdata_reg, wdata_next;
    logic [7:0]       rdata_sh_reg, rdata_sh_next;
    logic [10:0]      word_next;
    logic             cache_hit;

    logic       ss_n_reg, mosi_reg, req_ready_reg, rsp_valid_reg, busy_reg;
    logic [7:0] rsp_rdata_reg;

`ifdef SPI_ADDR_CACHE_EN
    logic [7:0] last_wr_addr_reg, last_rd_addr_reg;
    logic       last_wr_valid_reg, last_rd_valid_reg;
    logic       frame0_done;

    assign cache_hit = req_write ? (last_wr_valid_reg && (last_wr_addr_reg == req_addr))
                                 : (last_rd_valid_reg && (last_rd_addr_reg == req_addr));
    assign frame0_done = (state_reg == GAP) && (cnt_reg == GAP_LAST) && !frame_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_addr_reg  <= 8'h00;
            last_rd_addr_reg  <= 8'h00;
            last_wr_valid_reg <= 1'b0;
            last_rd_valid_reg <= 1'b0;
        end else if (frame0_done) begin
            if (write_reg) begin
                last_wr_addr_reg  <= addr_reg;
                last_wr_valid_reg <= 1'b1;
            end else begin
                last_rd_addr_reg  <= addr_reg;
                last_rd_valid_reg <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        bitcnt_next   = bitcnt_reg;
        cnt_next      = cnt_reg;
        frame_next    = frame_reg;
        write_next    = write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_sh_next = rdata_sh_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready_reg) begin
                    state_next  = SHIFT;
                    bitcnt_next = 4'd10;
                    frame_next  = cache_hit;
                    write_next  = req_write;
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                end
            end
            SHIFT: begin
                if (bitcnt_reg == 4'd0) begin
                    cnt_next = '0;
                    // Only the read-data frame (111) waits for and captures slave data
                    if (frame_reg && !write_reg)
                        state_next = (RD_LAT == 0) ? CAPT : WAIT;
                    else
                        state_next = TAIL;
                end else begin
                    bitcnt_next = bitcnt_reg - 4'd1;
                end
            end
            TAIL: begin
                state_next = GAP;
                cnt_next   = '0;
            end
            WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = CAPT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            CAPT: begin
                rdata_sh_next = {rdata_sh_reg[6:0], MISO};
                if (cnt_reg == CAPT_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    if (!frame_reg) begin
                        state_next  = SHIFT;
                        frame_next  = 1'b1;
                        bitcnt_next = 4'd10;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // cmd: write 000/001, read 110/111; the read-data frame carries a zero dummy byte
        word_next = {~write_next, ~write_next, frame_next,
                     frame_next ? (write_next ? wdata_next : 8'h00) : addr_next};
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bitcnt_reg    <= 4'd0;
            cnt_reg       <= '0;
            frame_reg     <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            rdata_sh_reg  <= 8'h00;
            ss_n_reg      <= 1'b1;
            mosi_reg      <= 1'b1;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 8'h00;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bitcnt_reg    <= bitcnt_next;
            cnt_reg       <= cnt_next;
            frame_reg     <= frame_next;
            write_reg     <= write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_sh_reg  <= rdata_sh_next;
            ss_n_reg      <= !(state_next inside {SHIFT, TAIL, WAIT, CAPT});
            mosi_reg      <= (state_next == SHIFT) ? word_next[bitcnt_next] : 1'b1;
            req_ready_reg <= (state_next == IDLE);
            rsp_valid_reg <= (state_next == DONE);
            busy_reg      <= (state_next != IDLE);
            if ((state_next == DONE) && !write_reg)
                rsp_rdata_reg <= rdata_sh_reg;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign busy      = busy_reg;
    assign SS_n      = ss_n_reg;
    assign MOSI      = mosi_reg;

endmodule

// File: tb/tb_spi_ram_master_seq.sv
// Bench for spi_ram_master_seq: behavioural SPI RAM slave, directed table, random ops vs a request-level model.
// Honours SPI_ADDR_CACHE_EN in the reference model when the design is built with it.
module tb_spi_ram_master_seq;

    localparam int G  = 2;
    localparam int RL = 2;
    localparam int LAT_W = 2 * (12 + G) + 1;
    localparam int LAT_R = (12 + G) + (11 + RL + 8 + G) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, busy, SS_n, MOSI;
    logic [7:0] rsp_rdata;
    logic       miso_tb = 1'b0;

    spi_ram_master_seq #(.GAP_CYCLES(G), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_tb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural SPI RAM slave plus bus monitor, all sampled on the falling edge
    logic [10:0] frames_q[$];
    int          gap_q[$];
    int          pulses = 0, rb_err = 0, mosi_err = 0, gap_run = 0;
    logic [7:0]  slv_mem [256] = '{default: 8'h00};
    logic [10:0] slv_sh = '0;
    int          slv_nb = 0, slv_wait = 0, slv_idx = 0;
    logic        slv_pend = 1'b0;
    logic [7:0]  slv_wr_addr = 8'h00, slv_rd_addr = 8'h00, slv_byte = 8'h00;

    initial forever begin
        @(negedge clk);
        if (rsp_valid) pulses++;
        if (req_ready && busy) rb_err++;
        if (slv_pend) begin
            if (slv_wait > 0) slv_wait--;
            else begin
                miso_tb = slv_byte[slv_idx-1];
                slv_idx--;
                if (slv_idx == 0) slv_pend = 1'b0;
            end
        end
        if (!SS_n) begin
            if (gap_run > 0) begin
                gap_q.push_back(gap_run);
                gap_run = 0;
            end
            if (slv_nb < 11) begin
                slv_sh = {slv_sh[9:0], MOSI};
                slv_nb++;
                if (slv_nb == 11) begin
                    frames_q.push_back(slv_sh);
                    case (slv_sh[10:8])
                        3'b000: slv_wr_addr = slv_sh[7:0];
                        3'b001: slv_mem[slv_wr_addr] = slv_sh[7:0];
                        3'b110: slv_rd_addr = slv_sh[7:0];
                        3'b111: begin
                            slv_pend = 1'b1;
                            slv_wait = RL;
                            slv_idx  = 8;
                            slv_byte = slv_mem[slv_rd_addr];
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            slv_nb = 0;
            if (!MOSI) mosi_err++;
            if (busy) gap_run++;
            else gap_run = 0;
        end
    end

    // Request-level reference model
    logic [7:0] ref_mem [256];
    logic       m_wr_valid = 1'b0, m_rd_valid = 1'b0;
    logic [7:0] m_wr_addr = 8'h00, m_rd_addr = 8'h00;

    function automatic bit model_hit(input bit w, input logic [7:0] a);
`ifdef SPI_ADDR_CACHE_EN
        return w ? (m_wr_valid && m_wr_addr == a) : (m_rd_valid && m_rd_addr == a);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_op(input bit w, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] exp_rd, output int exp_lat, output int exp_nf);
        bit hit;
        hit = model_hit(w, a);
        exp_nf  = hit ? 1 : 2;
        exp_lat = (hit ? 0 : 12 + G) + (w ? 12 + G : 11 + RL + 8 + G) + 1;
        exp_rd  = w ? 8'h00 : ref_mem[a];
        if (w) ref_mem[a] = d;
        if (w) begin m_wr_valid = 1'b1; m_wr_addr = a; end
        else   begin m_rd_valid = 1'b1; m_rd_addr = a; end
    endtask

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    task automatic run_op(input string tag, input bit w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int exp_lat, input int exp_nf, input bit keep);
        int n, acc, f0, g0, lat, fi;
        logic [10:0] ew, mask;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check($sformatf("%s accept_timeout", tag), req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc; f0 = frames_q.size(); g0 = gap_q.size();
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
        check($sformatf("%s busy_after_accept", tag), {busy, req_ready}, 2'b10);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check($sformatf("%s rsp_seen", tag), rsp_valid, 1);
        if (!rsp_valid) return;
        lat = cyc - acc;
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s busy_at_rsp", tag), busy, 1);
        if (!w) check($sformatf("%s rdata", tag), rsp_rdata, exp_rd);
        check($sformatf("%s nframes", tag), frames_q.size() - f0, exp_nf);
        if (frames_q.size() - f0 == exp_nf) begin
            for (int i = 0; i < exp_nf; i++) begin
                fi   = (exp_nf == 2) ? i : 1;
                ew   = {~w, ~w, fi[0], (fi == 1) ? (w ? d : 8'h00) : a};
                mask = (!w && fi == 1) ? 11'h700 : 11'h7FF;
                check($sformatf("%s frame%0d", tag, fi), frames_q[f0+i] & mask, ew & mask);
            end
        end
        if (exp_nf == 2) begin
            check($sformatf("%s ngaps", tag), gap_q.size() - g0, 1);
            if (gap_q.size() - g0 == 1) check($sformatf("%s gap_len", tag), gap_q[g0], G);
        end
        $display("op %s: %s addr=%02h wdata=%02h rdata=%02h latency=%0d frames=%0d",
                 tag, w ? "WR" : "RD", a, d, rsp_rdata, lat, frames_q.size() - f0);
        if (!keep) begin
            @(negedge clk);
            check($sformatf("%s idle_after", tag), {rsp_valid, busy, req_ready}, 3'b001);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_lat;
        bit         hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] mrd, w_d, w_a;
        int mlat, mnf, p0, start;
        bit hit, w_w, keep;

        vecs[0] = '{1'b1, 8'h55, 8'hAA, 8'h00, LAT_W, 1'b0};
        vecs[1] = '{1'b0, 8'h55, 8'h00, 8'hAA, LAT_R, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 8'h3C, 8'h00, LAT_W, 1'b1};
        vecs[3] = '{1'b1, 8'h11, 8'hC3, 8'h00, LAT_W, 1'b0};
        vecs[4] = '{1'b0, 8'h10, 8'h00, 8'h3C, LAT_R, 1'b0};
        vecs[5] = '{1'b0, 8'h11, 8'h00, 8'hC3, LAT_R, 1'b0};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {SS_n, MOSI, req_ready, rsp_valid, busy}, 5'b11100);
        check("reset_rdata", rsp_rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Directed table; entries 2..5 hold req_valid across two writes then read both back
        p0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) p0 = pulses;
            model_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, mrd, mlat, mnf);
            run_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_lat, 2, vecs[i].hold);
        end
        check("four_pulses", pulses - p0, 4);

        // Random ops on a small address window so the address cache sees hits
        for (int i = 0; i < 30; i++) begin
            w_w  = 1'($urandom);
            w_a  = 8'h20 + 8'($urandom_range(0, 3));
            w_d  = 8'($urandom);
            keep = (i != 29) && ($urandom_range(0, 3) == 0);
            model_op(w_w, w_a, w_d, mrd, mlat, mnf);
            run_op($sformatf("rnd%0d", i), w_w, w_a, w_d, mrd, mlat, mnf, keep);
        end

        // Reset during bit 5 of the read-data frame
        hit = model_hit(1'b0, 8'h55);
        start = hit ? 1 : 15;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h55; req_wdata = 8'h00;
        check("abort_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (start + 4) @(negedge clk);
        check("abort_in_frame", SS_n, 0);
        p0 = pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {SS_n, MOSI, busy, req_ready, rsp_valid}, 5'b11010);
        m_wr_valid = 1'b0; m_rd_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_rsp", pulses - p0, 0);
        check("abort_rdata_cleared", rsp_rdata, 8'h00);

        // Read 0x55 after the abort, then repeat it (second one hits when caching is built in)
        for (int i = 0; i < 2; i++) begin
            model_op(1'b0, 8'h55, 8'h00, mrd, mlat, mnf);
            run_op($sformatf("post_rst%0d", i), 1'b0, 8'h55, 8'h00, mrd, mlat, mnf, 1'b0);
            check($sformatf("post_rst%0d_value", i), rsp_rdata, 8'hAA);
        end
        model_op(1'b0, 8'h56, 8'h00, mrd, mlat, mnf);
        run_op("rd56", 1'b0, 8'h56, 8'h00, mrd, mlat, mnf, 1'b0);

        check("ready_while_busy", rb_err, 0);
        check("mosi_idle_high", mosi_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
